// File: rtl/rx_packet_ctrl_if.sv
// Handshake/bus bundle between the RX front end and FIFO on one side and
// rx_packet_ctrl on the other.
interface rx_packet_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 7
);
  logic              d_edge;
  logic              eop;
  logic              shift_enable;
  logic [DATA_W-1:0] rcv_data;
  logic              byte_received;
  logic              fifo_full;
  logic              rcving;
  logic              w_enable;
  logic              r_error;
  logic [2:0]        err_code;
  logic [CNT_W-1:0]  byte_count;
  logic              pkt_done;

  // Front-end / environment view: drives line events, observes controller status.
  modport master (
    output d_edge, eop, shift_enable, rcv_data, byte_received, fifo_full,
    input  rcving, w_enable, r_error, err_code, byte_count, pkt_done
  );

  // Controller view.
  modport slave (
    input  d_edge, eop, shift_enable, rcv_data, byte_received, fifo_full,
    output rcving, w_enable, r_error, err_code, byte_count, pkt_done
  );
endinterface

// File: rtl/rx_packet_ctrl.sv
// Receive control FSM: sync-byte check, FIFO write gating, payload counting and
// length/back-pressure/EOP/timeout faults reported through a sticky error code.
module rx_packet_ctrl #(
  parameter int unsigned       DATA_W       = 8,
  parameter logic [DATA_W-1:0] SYNC_PATTERN = 8'h80,
  parameter int unsigned       MAX_BYTES    = 64,
  parameter int unsigned       TIMEOUT_CYC  = 256,
  parameter int unsigned       CNT_W        = $clog2(MAX_BYTES + 1)
) (
  input logic             clk,
  input logic             n_rst,
  rx_packet_ctrl_if.slave bus
);

  localparam int unsigned      TmoW    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TmoW-1:0]  TmoMax  = TmoW'(TIMEOUT_CYC);
  localparam logic [TmoW-1:0]  TmoLast = (TIMEOUT_CYC > 0) ? TmoW'(TIMEOUT_CYC - 1) : '0;
  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(MAX_BYTES);

  localparam logic [2:0] ErrSync = 3'd1;
  localparam logic [2:0] ErrEop  = 3'd2;
  localparam logic [2:0] ErrOvf  = 3'd3;
  localparam logic [2:0] ErrFull = 3'd4;
  localparam logic [2:0] ErrTmo  = 3'd5;

  typedef enum logic [3:0] {
    StIdle, StSyncRcv, StSyncChk, StDataRcv, StWrite,
    StGap, StDone, StErrDrain, StErrWait, StErrIdle
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] byte_count_q, byte_count_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic             pkt_done_q, pkt_done_d;

  logic            se_eop;
  logic            tmo_fire;
  logic [TmoW-1:0] tmo_inc;

  assign se_eop   = bus.shift_enable & bus.eop;
  // Fires on the TIMEOUT_CYC-th consecutive strobe-less cycle.
  assign tmo_fire = (TIMEOUT_CYC != 0) && !bus.shift_enable && (tmo_q == TmoLast);
  assign tmo_inc  = (tmo_q == TmoMax) ? tmo_q : tmo_q + 1'b1;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= StIdle;
      err_code_q   <= '0;
      byte_count_q <= '0;
      tmo_q        <= '0;
      pkt_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      err_code_q   <= err_code_d;
      byte_count_q <= byte_count_d;
      tmo_q        <= tmo_d;
      pkt_done_q   <= pkt_done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    err_code_d   = err_code_q;
    byte_count_d = byte_count_q;
    tmo_d        = tmo_q;

    if (state_q inside {StSyncRcv, StDataRcv, StGap}) begin
      tmo_d = bus.shift_enable ? '0 : tmo_inc;
    end

    // Error codes are only written on exits from running states, so the first fault sticks.
    unique case (state_q)
      StIdle, StErrIdle: begin
        if (bus.d_edge) begin
          state_d      = StSyncRcv;
          err_code_d   = '0;
          byte_count_d = '0;
          tmo_d        = '0;
        end
      end
      StSyncRcv: begin
        if (bus.byte_received) begin
          state_d = StSyncChk;
        end else if (se_eop) begin
          state_d    = StErrWait;
          err_code_d = ErrEop;
        end else if (tmo_fire) begin
          state_d    = StErrWait;
          err_code_d = ErrTmo;
        end
      end
      StSyncChk: begin
        if (bus.rcv_data == SYNC_PATTERN) begin
          state_d = StDataRcv;
        end else begin
          state_d    = StErrDrain;
          err_code_d = ErrSync;
        end
      end
      StDataRcv: begin
        if (se_eop) begin
          state_d    = StErrWait;
          err_code_d = ErrEop;
        end else if (bus.byte_received && (byte_count_q == CntMax)) begin
          state_d    = StErrDrain;
          err_code_d = ErrOvf;
        end else if (bus.byte_received && bus.fifo_full) begin
          state_d    = StErrDrain;
          err_code_d = ErrFull;
        end else if (bus.byte_received) begin
          state_d = StWrite;
        end else if (tmo_fire) begin
          state_d    = StErrWait;
          err_code_d = ErrTmo;
        end
      end
      StWrite: begin
        state_d      = StGap;
        byte_count_d = byte_count_q + 1'b1;
      end
      StGap: begin
        if (bus.shift_enable) begin
          state_d = bus.eop ? StDone : StDataRcv;
        end else if (tmo_fire) begin
          state_d    = StErrWait;
          err_code_d = ErrTmo;
        end
      end
      StDone: begin
        if (bus.d_edge) state_d = StIdle;
      end
      StErrDrain: begin
        if (se_eop) state_d = StErrWait;
      end
      StErrWait: begin
        if (bus.d_edge) state_d = StErrIdle;
      end
      default: state_d = StIdle;
    endcase

    pkt_done_d = (state_d == StDone) && (state_q != StDone);
  end

  // Moore output decode
  always_comb begin
    bus.rcving   = 1'b0;
    bus.r_error  = 1'b0;
    bus.w_enable = 1'b0;
    unique case (state_q)
      StSyncRcv, StSyncChk, StDataRcv, StGap: bus.rcving = 1'b1;
      StWrite: begin
        bus.rcving   = 1'b1;
        bus.w_enable = 1'b1;
      end
      StErrDrain: begin
        bus.rcving  = 1'b1;
        bus.r_error = 1'b1;
      end
      StErrWait, StErrIdle: bus.r_error = 1'b1;
      default: ;
    endcase
  end

  assign bus.err_code   = err_code_q;
  assign bus.byte_count = byte_count_q;
  assign bus.pkt_done   = pkt_done_q;

endmodule
